uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that sits downstream of the core's store path.
- Snoops the same store strobe, address, mask and rs2 data that go to data memory, and captures bytes written to its data address into a TX FIFO.
- Serialises captured bytes as 8N1 frames on a single output pin.
- A status word is readable so software can poll busy/full before storing.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- UART_ADDR, 32'hf6fff070, byte address of the TX data register; the status register is at UART_ADDR+4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  store strobe from the core.
- w_addr  input  32  store byte address.
- w_data  input  32  store data (rs2).
- w_mask  input  4  byte-enable mask; bit0 = byte lane 0.
- r_addr  input  32  load address from the core.
- r_data  output  32  status word when r_addr==UART_ADDR+4, else 0; combinational.
- uart_tx  output  1  serial line; idles high; registered.
- tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset: single clock; reset is synchronous and active-high.
  - Reset values: uart_tx=1, tx_busy=0, FIFO empty (read/write pointers 0), overflow=0, FSM=IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts immediately. uart_tx is 1 after the reset edge and FIFO contents are discarded.
- Push:
  - A push occurs on an edge with wr_en && w_addr==UART_ADDR && w_mask[0]; the pushed byte is w_data[7:0].
  - w_mask[0]==0 at UART_ADDR: ignored.
  - Writes to any other address: ignored.
- Overflow:
  - A push while the FIFO is full and no pop happens that edge drops the byte and sets overflow (sticky).
  - Push and pop on the same edge while full: the push is accepted and the count is unchanged.
- Clearing overflow: a store with wr_en && w_addr==UART_ADDR+4 && w_mask[0] && w_data[3]==1 clears overflow. A push on the same edge takes priority only for the FIFO, not for the flag.
- Status word: bit0=tx_busy, bit1=fifo_full, bit2=fifo_empty, bit3=overflow, bits31:4=0.
- FIFO implementation: circular, with pointers one bit wider than log2(FIFO_DEPTH).
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register, set uart_tx=0, reset the baud counter, go to START. Otherwise uart_tx=1.
  - START: hold for CLKS_PER_BIT cycles, then drive shift[0], bit index=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7 completes, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Latency:
  - uart_tx falls at the first edge after the edge that pushed into an empty FIFO with the FSM in IDLE.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1; the bit advances on the edge where the counter equals CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT).
- tx_busy = (FSM != IDLE) || !empty. It is registered from next-state so it stays consistent with the status read.

Optional Feature:
- UART_PARITY_EN defined:
  - The PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - The parity bit is even parity: XOR of the 8 data bits.
  - A frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; a frame is 10*CLKS_PER_BIT cycles.

Test Plan:
- CLKS_PER_BIT=4, reset, then store 0x41 to UART_ADDR with mask 4'b0001:
  - uart_tx reads 0 for 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), then 1 for 4 cycles; total 40 cycles.
  - tx_busy falls on the cycle the FSM returns to IDLE.
- Push 0x55, 0xAA on consecutive cycles: two frames back-to-back with no idle cycle between the stop bit and the second start bit; 80 cycles total.
- FIFO_DEPTH=4, push 6 bytes in 6 consecutive cycles while the first frame starts:
  - The first byte is popped at edge 2, so bytes 1-5 are accepted and byte 6 is dropped.
  - Status reads 0x0B (busy, full, overflow).
  - A store of 0x8 to UART_ADDR+4 then gives status bit3=0.
- Store to UART_ADDR with mask 4'b0000, and a store to UART_ADDR+8: no frame, status stays 0x4.
- Assert rst mid-DATA of a frame with 2 bytes queued: the next cycle shows uart_tx=1, status=0x4, and no further frames.
- With UART_PARITY_EN, send 0x07: the parity bit is 1 and the frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-snooping 8N1 UART transmitter with TX FIFO and status word; define UART_PARITY_EN for an even parity bit
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] UART_ADDR    = 32'hf6fff070
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_mask,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  output logic        uart_tx,
  output logic        tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_PARITY_EN
    , S_PARITY
`endif
  } state_t;
  state_t state_q, state_d;
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
  logic push_req, clr_req, push, pop, full, empty, tick;
  logic unused_bits;
  assign push_req = wr_en && w_addr == UART_ADDR && w_mask[0];
  assign clr_req = wr_en && w_addr == UART_ADDR + 32'd4 && w_mask[0] && w_data[3];
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  assign head = fifo_q[rp_q[AW-1:0]];
  assign tick = cnt_q == LAST;
  // A full FIFO still accepts a push on the edge that pops its head
  assign push = push_req && (!full || pop);
  assign wp_d = wp_q + (AW+1)'(push);
  assign rp_d = rp_q + (AW+1)'(pop);
  assign ovf_d = clr_req ? 1'b0 : (push_req && full && !pop) ? 1'b1 : ovf_q;
  // Busy is computed from next state so the status read agrees with the line
  assign busy_d = state_d != S_IDLE || wp_d != rp_d;
  assign r_data = r_addr == UART_ADDR + 32'd4 ? {28'd0, ovf_q, empty, full, busy_q} : 32'd0;
  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
  assign unused_bits = ^{w_data[31:8], w_mask[3:1]};
  // Frame sequencer: pops a byte, then walks start, data, (parity,) stop bits
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = empty;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        tx_d = shift_q[0];
        idx_d = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
          tx_d = ^shift_q;
          state_d = S_PARITY;
`else
          tx_d = 1'b1;
          state_d = S_STOP;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d = shift_q[idx_q + 3'd1];
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tick) begin
        tx_d = 1'b1;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        tx_d = empty;
        state_d = empty ? S_IDLE : S_START;
        pop = !empty;
        shift_d = empty ? shift_q : head;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State, pointer and line registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  // FIFO storage; stale contents are unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q[AW-1:0]] <= w_data[7:0];
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized scoreboard bench for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] UA = 32'hf6fff070;
  localparam logic [31:0] SA = UA + 32'd4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;
  logic clk = 0, rst = 1, wr_en = 0;
  logic [31:0] w_addr = 0, w_data = 0, r_addr = SA;
  logic [3:0] w_mask = 0;
  logic [31:0] r_data;
  logic uart_tx, tx_busy;
  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .UART_ADDR(UA)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .w_mask(w_mask), .r_addr(r_addr), .r_data(r_data), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [7:0] b; int t;} exp_t;
  exp_t exq[$];
  logic [7:0] mq[$];
  int frame_end = 0, rst_edge = -1;
  bit m_ovf = 0;
  int chk_s = 0, err_s = 0, chk_m = 0, err_m = 0;
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_s++;
    if (act !== expv) begin
      err_s++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask
  // One clock edge: model the edge at the transaction level, apply it, compare status
  task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit r, input logic [31:0] ra);
    int n;
    bit pop, full_b;
    logic [31:0] st;
    wr_en = w; w_addr = a; w_data = d; w_mask = m; rst = r; r_addr = ra;
    n = cyc + 1;
    if (r) begin
      mq.delete();
      frame_end = 0;
      m_ovf = 0;
      rst_edge = n;
    end else begin
      full_b = mq.size() == D;
      pop = mq.size() > 0 && n >= frame_end;
      if (pop) begin
        exq.push_back('{mq.pop_front(), n});
        frame_end = n + FL;
      end
      if (w && a == UA && m[0]) begin
        if (!full_b || pop) mq.push_back(d[7:0]);
        else m_ovf = 1;
      end
      if (w && a == SA && m[0] && d[3]) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    st = {28'd0, m_ovf, mq.size() == 0, mq.size() == D, (n < frame_end) || mq.size() > 0};
    chk("status", r_data, ra == SA ? st : 32'd0);
    chk("tx_busy", {31'd0, tx_busy}, {31'd0, st[0]});
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 32'd0, 32'd0, 4'd0, 0, SA);
  endtask
  task automatic push(input logic [7:0] b);
    step(1, UA, {24'($urandom), b}, 4'b0001, 0, SA);
  endtask
  // Monitor: decodes each frame off the line and compares it to the scoreboard head
  bit mon_on = 0;
  int mon_j = 0, mon_bad = 0;
  logic [NB-1:0] mon_f = '1;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_edge == cyc) begin
      mon_on = 0;
      chk_m++;
      if (uart_tx !== 1'b1) begin
        err_m++;
        $display("FAIL reset_tx: got %b expected 1 at cycle %0d", uart_tx, cyc);
      end
    end else if (!mon_on) begin
      if (uart_tx === 1'b0) begin
        chk_m++;
        if (exq.size() == 0) begin
          err_m++;
          $display("FAIL unexpected_start: line low with no frame queued at cycle %0d", cyc);
        end else begin
          mon_e = exq.pop_front();
          if (mon_e.t != cyc) begin
            err_m++;
            $display("FAIL start_time: got cycle %0d expected %0d", cyc, mon_e.t);
          end
          mon_f = frame_bits(mon_e.b);
          mon_on = 1;
          mon_j = 1;
          mon_bad = 0;
        end
      end
    end else begin
      if (uart_tx !== mon_f[mon_j / C]) mon_bad++;
      mon_j++;
      if (mon_j == FL) begin
        chk_m++;
        mon_on = 0;
        if (mon_bad != 0) begin
          err_m++;
          $display("FAIL frame: byte %h had %0d wrong line cycles, expected 0", mon_e.b, mon_bad);
        end
      end
    end
  end
  initial begin
    int pct;
    logic [31:0] a, ra;
    step(0, 32'd0, 32'd0, 4'd0, 1, SA);
    step(0, 32'd0, 32'd0, 4'd0, 1, SA);
    chk("reset_status", r_data, 32'h4);
    push(8'h41);
    idle(45);
    push(8'h55);
    push(8'hAA);
    idle(85);
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    chk("overflow_status", r_data, 32'hB);
    step(1, SA, 32'h8, 4'b0001, 0, SA);
    chk("overflow_clear", {31'd0, r_data[3]}, 32'd0);
    idle(220);
    step(1, UA, 32'h77, 4'b0000, 0, SA);
    step(1, UA + 32'd8, 32'h77, 4'b0001, 0, SA);
    idle(3);
    chk("ignored_status", r_data, 32'h4);
    push(8'h07);
    idle(50);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    idle(16);
    step(0, 32'd0, 32'd0, 4'd0, 1, SA);
    chk("midframe_rst_status", r_data, 32'h4);
    idle(60);
    for (int i = 0; i < 1500; i++) begin
      pct = ((i / 300) % 2) ? 25 : 3;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = UA;
        6, 7: a = SA;
        8: a = UA + 32'd8;
        default: a = $urandom;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? $urandom : SA;
      step($urandom_range(0, 99) < pct, a, $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0001,
           $urandom_range(0, 399) == 0, ra);
    end
    for (int k = 0; k < 3000 && (mq.size() > 0 || cyc < frame_end + 2 || mon_on); k++) idle(1);
    idle(2);
    chk("drained", exq.size() + mq.size() + {31'd0, mon_on}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk_s + chk_m, err_s + err_m);
    $finish;
  end
endmodule
